// File: rtl/serial_mul_fu_if.sv
// Issue/writeback port bundle for the bit-serial multiply unit.
// The issue stage drives master; the functional unit implements slave.
interface serial_mul_fu_if #(
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned XLEN          = 64
) ();
    logic                     valid_i;
    logic                     ready_o;
    logic [1:0]               op_i;
    logic [TRANS_ID_BITS-1:0] trans_id_i;
    logic [XLEN-1:0]          operand_a_i;
    logic [XLEN-1:0]          operand_b_i;
    logic                     valid_o;
    logic [TRANS_ID_BITS-1:0] trans_id_o;
    logic [XLEN-1:0]          result_o;
    logic                     ex_valid_o;

    modport master (
        output valid_i, op_i, trans_id_i, operand_a_i, operand_b_i,
        input  ready_o, valid_o, trans_id_o, result_o, ex_valid_o
    );

    modport slave (
        input  valid_i, op_i, trans_id_i, operand_a_i, operand_b_i,
        output ready_o, valid_o, trans_id_o, result_o, ex_valid_o
    );
endinterface

// File: rtl/serial_mul_fu.sv
// Bit-serial shift-add multiplier: one operation in flight, XLEN steps per op,
// single-cycle writeback pulse tagged with the issuing transaction ID.
module serial_mul_fu #(
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned XLEN          = 64
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           flush_i,
    serial_mul_fu_if.slave fu
);
    localparam int unsigned ACC_W = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULH   = 2'd1;
    localparam logic [1:0] OP_MULHSU = 2'd2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e                   state_q, state_d;
    logic [1:0]               op_q, op_d;
    logic                     neg_q, neg_d;
    logic [XLEN-1:0]          mag_a_q, mag_a_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [TRANS_ID_BITS-1:0] tid_q, tid_d;
    logic [TRANS_ID_BITS-1:0] tid_out_q, tid_out_d;
    logic [XLEN-1:0]          res_q, res_d;

    logic                     ready_c, accept_c, a_neg_c, b_neg_c;
    logic [XLEN-1:0]          mag_a_in_c, mag_b_in_c;
    logic [XLEN:0]            sum_c;
    logic [ACC_W-1:0]         acc_step_c, prod_c;

    assign ready_c  = (state_q != BUSY) & ~flush_i;
    assign accept_c = fu.valid_i & ready_c;

    // Signedness per op: a is signed for MULH/MULHSU, b only for MULH.
    assign a_neg_c    = ((fu.op_i == OP_MULH) | (fu.op_i == OP_MULHSU)) & fu.operand_a_i[XLEN-1];
    assign b_neg_c    = (fu.op_i == OP_MULH) & fu.operand_b_i[XLEN-1];
    assign mag_a_in_c = a_neg_c ? (~fu.operand_a_i + XLEN'(1)) : fu.operand_a_i;
    assign mag_b_in_c = b_neg_c ? (~fu.operand_b_i + XLEN'(1)) : fu.operand_b_i;

    // The accumulator's low half doubles as the multiplier shift register:
    // the bit consumed each step is acc_q[0], and product bits shift in behind it.
    assign sum_c      = {1'b0, acc_q[ACC_W-1:XLEN]} + {1'b0, (acc_q[0] ? mag_a_q : {XLEN{1'b0}})};
    assign acc_step_c = {sum_c, acc_q[XLEN-1:1]};
    assign prod_c     = neg_q ? (~acc_step_c + ACC_W'(1)) : acc_step_c;

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_d     = neg_q;
        mag_a_d   = mag_a_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        tid_d     = tid_q;
        tid_out_d = tid_out_q;
        res_d     = res_q;

        case (state_q)
            IDLE: state_d = IDLE;
            BUSY: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step_c;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d   = DONE;
                        tid_out_d = tid_q;
                        res_d     = (op_q == OP_MUL) ? prod_c[XLEN-1:0] : prod_c[ACC_W-1:XLEN];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept_c) begin
            state_d = BUSY;
            op_d    = fu.op_i;
            tid_d   = fu.trans_id_i;
            neg_d   = a_neg_c ^ b_neg_c;
            mag_a_d = mag_a_in_c;
            acc_d   = {{XLEN{1'b0}}, mag_b_in_c};
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            op_q      <= '0;
            neg_q     <= 1'b0;
            mag_a_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            tid_q     <= '0;
            tid_out_q <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            mag_a_q   <= mag_a_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            tid_q     <= tid_d;
            tid_out_q <= tid_out_d;
            res_q     <= res_d;
        end
    end

    assign fu.ready_o    = ready_c;
    assign fu.valid_o    = (state_q == DONE) & ~flush_i;
    assign fu.trans_id_o = tid_out_q;
    assign fu.result_o   = res_q;
    assign fu.ex_valid_o = 1'b0;
endmodule

// File: tb/tb_serial_mul_fu.sv
// Self-checking bench for serial_mul_fu: directed corner products, random ops
// against a wide-arithmetic reference model, flush, back-to-back and reset.
module tb_serial_mul_fu;
    localparam int unsigned TID_W = 3;
    localparam int unsigned XLEN  = 64;
    localparam int          LAT   = 65;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_mul_fu_if #(.TRANS_ID_BITS(TID_W), .XLEN(XLEN)) bus ();

    serial_mul_fu #(.TRANS_ID_BITS(TID_W), .XLEN(XLEN)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .fu      (bus)
    );

    // Reference: extend each operand to 128 bits by its signedness and multiply.
    function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb, p;
        ea = (op == 2'd1 || op == 2'd2) ? {{64{a[63]}}, a} : {64'd0, a};
        eb = (op == 2'd1) ? {{64{b[63]}}, b} : {64'd0, b};
        p  = ea * eb;
        return (op == 2'd0) ? p[63:0] : p[127:64];
    endfunction

    function automatic logic [63:0] rand_operand();
        int unsigned pick;
        pick = $urandom_range(0, 6);
        case (pick)
            0:       return 64'd0;
            1:       return 64'h8000_0000_0000_0000;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Present one op at the current negedge; returns one negedge later (index 1).
    task automatic issue_op(input logic [1:0] op, input logic [2:0] tid, input logic [63:0] a, input logic [63:0] b);
        bus.valid_i     = 1'b1;
        bus.op_i        = op;
        bus.trans_id_i  = tid;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    // Watch for the writeback pulse; lat is the negedge index (-1 if none in budget).
    task automatic wait_wb(input int budget, output int lat, output logic [63:0] res,
                           output logic [2:0] tid, output int ready_hi);
        lat = -1; res = '0; tid = '0; ready_hi = 0;
        for (int i = 1; i <= budget; i++) begin
            if (i > 1) @(negedge clk);
            if (bus.valid_o) begin
                lat = i; res = bus.result_o; tid = bus.trans_id_o;
                break;
            end
            if (bus.ready_o) ready_hi++;
        end
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.valid_o) pulses++;
        end
    endtask

    task automatic test_reset();
        checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
        checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
        checks++; if (bus.trans_id_o !== 3'd0) begin failures++; $display("FAIL reset_tid: got %0d want 0", bus.trans_id_o); end
        checks++; if (bus.result_o !== 64'd0) begin failures++; $display("FAIL reset_result: got %h want 0", bus.result_o); end
        checks++; if (bus.ex_valid_o !== 1'b0) begin failures++; $display("FAIL reset_ex_valid: got %b want 0", bus.ex_valid_o); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b want 1", bus.ready_o); end
    endtask

    task automatic test_directed();
        logic [1:0]  ops  [6] = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
        logic [63:0] as   [6] = '{64'd3, '1, '1, '1, '1, 64'h8000_0000_0000_0000};
        logic [63:0] bs   [6] = '{64'd5, '1, '1, '1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        logic [63:0] exps [6] = '{64'd15, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE,
                                  64'hFFFF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000};
        logic [2:0]  tids [6] = '{3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
        int lat, rhi;
        logic [63:0] res;
        logic [2:0] tid;
        for (int k = 0; k < 6; k++) begin
            issue_op(ops[k], tids[k], as[k], bs[k]);
            wait_wb(100, lat, res, tid, rhi);
            checks++; if (lat !== LAT) begin failures++; $display("FAIL dir%0d_latency: got %0d want %0d", k, lat, LAT); end
            checks++; if (res !== exps[k]) begin failures++; $display("FAIL dir%0d_result: got %h want %h", k, res, exps[k]); end
            checks++; if (tid !== tids[k]) begin failures++; $display("FAIL dir%0d_tid: got %0d want %0d", k, tid, tids[k]); end
            checks++; if (rhi !== 0) begin failures++; $display("FAIL dir%0d_ready_in_busy: got %0d cycles high want 0", k, rhi); end
            @(negedge clk);
            checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL dir%0d_single_pulse: got %b want 0", k, bus.valid_o); end
        end
    endtask

    task automatic test_random();
        int lat, rhi;
        logic [63:0] res, a, b, exp;
        logic [2:0] tid, etid;
        logic [1:0] op;
        for (int k = 0; k < 24; k++) begin
            op   = 2'($urandom_range(0, 3));
            etid = 3'($urandom_range(0, 7));
            a    = rand_operand();
            b    = rand_operand();
            exp  = ref_mul(op, a, b);
            issue_op(op, etid, a, b);
            wait_wb(100, lat, res, tid, rhi);
            checks++; if (res !== exp) begin failures++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h want %h", k, op, a, b, res, exp); end
            checks++; if (tid !== etid) begin failures++; $display("FAIL rnd%0d_tid: got %0d want %0d", k, tid, etid); end
            checks++; if (lat !== LAT) begin failures++; $display("FAIL rnd%0d_latency: got %0d want %0d", k, lat, LAT); end
            @(negedge clk);
        end
    endtask

    task automatic test_flush();
        int lat, rhi, pulses;
        logic [63:0] res;
        logic [2:0] tid;
        // Flush in BUSY at cycle 30.
        issue_op(2'd0, 3'd4, 64'd11, 64'd13);
        repeat (29) @(negedge clk);
        flush = 1'b1;
        #1;
        checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL flush_busy_ready: got %b want 0", bus.ready_o); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL flush_ready_after: got %b want 1", bus.ready_o); end
        count_pulses(80, pulses);
        checks++; if (pulses !== 0) begin failures++; $display("FAIL flush_busy_no_wb: got %0d pulses want 0", pulses); end
        issue_op(2'd0, 3'd2, 64'd1234, 64'd5678);
        wait_wb(100, lat, res, tid, rhi);
        checks++; if (res !== 64'd7006652) begin failures++; $display("FAIL flush_next_result: got %0d want 7006652", res); end
        checks++; if (tid !== 3'd2) begin failures++; $display("FAIL flush_next_tid: got %0d want 2", tid); end
        checks++; if (lat !== LAT) begin failures++; $display("FAIL flush_next_latency: got %0d want %0d", lat, LAT); end
        @(negedge clk);

        // valid_i together with flush_i in IDLE is not accepted.
        bus.valid_i = 1'b1; bus.op_i = 2'd0; bus.trans_id_i = 3'd7;
        bus.operand_a_i = 64'd9; bus.operand_b_i = 64'd9;
        flush = 1'b1;
        #1;
        checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL flush_idle_ready: got %b want 0", bus.ready_o); end
        @(negedge clk);
        bus.valid_i = 1'b0; flush = 1'b0;
        count_pulses(80, pulses);
        checks++; if (pulses !== 0) begin failures++; $display("FAIL flush_idle_not_accepted: got %0d pulses want 0", pulses); end

        // Flush in the DONE cycle suppresses the pulse.
        issue_op(2'd0, 3'd3, 64'd2, 64'd2);
        repeat (64) @(negedge clk);
        checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL flush_done_pre: got %b want 1", bus.valid_o); end
        flush = 1'b1;
        #1;
        checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL flush_done_valid: got %b want 0", bus.valid_o); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL flush_done_ready: got %b want 1", bus.ready_o); end
        count_pulses(70, pulses);
        checks++; if (pulses !== 0) begin failures++; $display("FAIL flush_done_no_wb: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a1, b1, a2, b2, r1, r2, e1, e2;
        logic [2:0] id1, id2;
        int t1, t2, n;
        bit drop_next;
        logic rdy_done;
        a1 = rand_operand(); b1 = rand_operand();
        a2 = rand_operand(); b2 = rand_operand();
        e1 = ref_mul(2'd1, a1, b1);
        e2 = ref_mul(2'd3, a2, b2);
        t1 = -1; t2 = -1; n = 0; drop_next = 0; rdy_done = 1'b0;
        r1 = '0; r2 = '0; id1 = '0; id2 = '0;
        issue_op(2'd1, 3'd1, a1, b1);
        bus.valid_i = 1'b1; bus.op_i = 2'd3; bus.trans_id_i = 3'd2;
        bus.operand_a_i = a2; bus.operand_b_i = b2;
        for (int i = 1; i <= 200; i++) begin
            if (i > 1) @(negedge clk);
            if (drop_next) begin bus.valid_i = 1'b0; drop_next = 0; end
            if (bus.valid_o) begin
                if (n == 0) begin
                    t1 = i; r1 = bus.result_o; id1 = bus.trans_id_o;
                    rdy_done = bus.ready_o; drop_next = 1;
                end else begin
                    t2 = i; r2 = bus.result_o; id2 = bus.trans_id_o;
                    break;
                end
                n++;
            end
        end
        bus.valid_i = 1'b0;
        checks++; if (t1 !== LAT) begin failures++; $display("FAIL b2b_first_latency: got %0d want %0d", t1, LAT); end
        checks++; if (t2 - t1 !== LAT) begin failures++; $display("FAIL b2b_interval: got %0d want %0d", t2 - t1, LAT); end
        checks++; if (rdy_done !== 1'b1) begin failures++; $display("FAIL b2b_ready_in_done: got %b want 1", rdy_done); end
        checks++; if (r1 !== e1 || id1 !== 3'd1) begin failures++; $display("FAIL b2b_first: got %h/%0d want %h/1", r1, id1, e1); end
        checks++; if (r2 !== e2 || id2 !== 3'd2) begin failures++; $display("FAIL b2b_second: got %h/%0d want %h/2", r2, id2, e2); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        int lat, rhi, pulses;
        logic [63:0] res;
        logic [2:0] tid;
        issue_op(2'd0, 3'd6, 64'd3, 64'd7);
        wait_wb(100, lat, res, tid, rhi);
        checks++; if (res !== 64'd21 || tid !== 3'd6) begin failures++; $display("FAIL rst_pre_op: got %0d/%0d want 21/6", res, tid); end
        @(negedge clk);
        issue_op(2'd3, 3'd5, 64'hDEAD_BEEF_0000_1111, 64'hFFFF_0000_FFFF_0000);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL rst_mid_ready: got %b want 1", bus.ready_o); end
        checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b want 0", bus.valid_o); end
        checks++; if (bus.trans_id_o !== 3'd0) begin failures++; $display("FAIL rst_mid_tid: got %0d want 0", bus.trans_id_o); end
        checks++; if (bus.result_o !== 64'd0) begin failures++; $display("FAIL rst_mid_result: got %h want 0", bus.result_o); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %b want 1", bus.ready_o); end
        count_pulses(80, pulses);
        checks++; if (pulses !== 0) begin failures++; $display("FAIL rst_mid_no_wb: got %0d pulses want 0", pulses); end
        issue_op(2'd2, 3'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd10);
        wait_wb(100, lat, res, tid, rhi);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF || tid !== 3'd7 || lat !== LAT) begin
            failures++; $display("FAIL rst_after_op: got %h/%0d/%0d want ffffffffffffffff/7/%0d", res, tid, lat, LAT);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.valid_i     = 1'b0;
        bus.op_i        = 2'd0;
        bus.trans_id_i  = '0;
        bus.operand_a_i = '0;
        bus.operand_b_i = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
